light_pwm_driver: RTL and testbench



---
 rtl/light_pkg.sv | 30 +++
 rtl/pwm_timebase.sv | 45 ++++
 rtl/light_pwm_driver.sv | 100 ++++++++++
 tb/tb_light_pwm_driver.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/light_pkg.sv
// Shared light-level definitions used by the light-stand FSM and the PWM driver.
package light_pkg;

    // Level codes emitted by the light-stand FSM.
    typedef enum logic [2:0] {
        LIGHT0 = 3'b000,
        LIGHT1 = 3'b001,
        LIGHT2 = 3'b010,
        LIGHT3 = 3'b011,
        LIGHT4 = 3'b100
    } light_level_e;

    localparam int unsigned NUM_LEVELS = 5;

    // Map a level code to a duty in ticks; unknown codes (5..7) mean off.
    function automatic int unsigned level_to_duty(input logic [2:0] level,
                                                  input int unsigned period);
        int unsigned duty;
        duty = 0;
        case (level)
            LIGHT1:  duty = period / 4;
            LIGHT2:  duty = period / 2;
            LIGHT3:  duty = (3 * period) / 4;
            LIGHT4:  duty = period;
            default: duty = 0;
        endcase
        return duty;
    endfunction

endpackage

// File: rtl/pwm_timebase.sv
// PWM timebase: clock prescaler plus period counter, shareable between channels.
module pwm_timebase #(
    parameter int unsigned CLK_DIV = 100,
    parameter int unsigned PERIOD  = 100,
    parameter int unsigned DUTY_W  = 8
) (
    input  logic              i_clk,
    input  logic              i_reset,
    output logic              o_tick,
    output logic [DUTY_W-1:0] o_cnt,
    output logic              o_boundary
);

    localparam int unsigned        PRESC_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLK_DIV - 1);
    localparam logic [DUTY_W-1:0]  CNT_MAX   = DUTY_W'(PERIOD - 1);

    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [DUTY_W-1:0]  cnt_q, cnt_d;

    // Next-state for prescaler and period counter; the counter only moves on a tick.
    always_comb begin
        o_tick     = (presc_q == PRESC_MAX);
        o_boundary = o_tick && (cnt_q == CNT_MAX);
        presc_d    = o_tick ? '0 : presc_q + 1'b1;
        cnt_d      = cnt_q;
        if (o_tick) begin
            cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
        end
    end

    // Counter state registers.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            presc_q <= '0;
            cnt_q   <= '0;
        end else begin
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_cnt = cnt_q;

endmodule

// File: rtl/light_pwm_driver.sv
// Converts the light-stand level code into a glitch-free PWM drive with optional fade.
module light_pwm_driver
    import light_pkg::*;
#(
    parameter int unsigned CLK_DIV   = 100,
    parameter int unsigned PERIOD    = 100,
    parameter int unsigned FADE_STEP = 0,
    parameter int unsigned DUTY_W    = 8
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [2:0]        i_lightState,
    input  logic              i_enable,
    output logic              o_pwm,
    output logic [DUTY_W-1:0] o_duty,
    output logic              o_period_start,
    output logic              o_busy
);

    localparam logic [DUTY_W-1:0] STEP = DUTY_W'(FADE_STEP);

    logic [2:0]        level_q;
    logic              en_q;
    logic              tick;
    logic              boundary;
    logic [DUTY_W-1:0] cnt;
    logic [DUTY_W-1:0] cnt_next;
    logic [DUTY_W-1:0] target;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic [DUTY_W:0]   up_sum;
    logic [DUTY_W:0]   down_floor;
    logic              pwm_q, ps_q, busy_q;

    // Sample the asynchronous-domain inputs; everything downstream uses these copies.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            level_q <= '0;
            en_q    <= 1'b0;
        end else begin
            level_q <= i_lightState;
            en_q    <= i_enable;
        end
    end

    pwm_timebase #(
        .CLK_DIV (CLK_DIV),
        .PERIOD  (PERIOD),
        .DUTY_W  (DUTY_W)
    ) u_timebase (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .o_tick     (tick),
        .o_cnt      (cnt),
        .o_boundary (boundary)
    );

    assign target = DUTY_W'(level_to_duty(level_q, PERIOD));

    // Duty only moves on a period boundary; fade arithmetic is one bit wider so it never wraps.
    always_comb begin
        up_sum     = {1'b0, duty_q} + {1'b0, STEP};
        down_floor = {1'b0, target} + {1'b0, STEP};
        cnt_next   = cnt;
        if (tick) begin
            cnt_next = boundary ? '0 : cnt + 1'b1;
        end
        duty_d = duty_q;
        if (boundary) begin
            if (FADE_STEP == 0) begin
                duty_d = target;
            end else if (duty_q < target) begin
                duty_d = (up_sum >= {1'b0, target}) ? target : up_sum[DUTY_W-1:0];
            end else if (duty_q > target) begin
                // duty - step <= target  <=>  duty <= target + step
                duty_d = ({1'b0, duty_q} <= down_floor) ? target : duty_q - STEP;
            end
        end
    end

    // Registered outputs; PWM compares post-update count and duty so a new period starts clean.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            duty_q <= '0;
            pwm_q  <= 1'b0;
            ps_q   <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            duty_q <= duty_d;
            pwm_q  <= en_q && (cnt_next < duty_d);
            ps_q   <= boundary;
            busy_q <= (duty_d != target);
        end
    end

    assign o_pwm          = pwm_q;
    assign o_duty         = duty_q;
    assign o_period_start = ps_q;
    assign o_busy         = busy_q;

endmodule

// File: tb/tb_light_pwm_driver.sv
// Self-checking bench for light_pwm_driver: three instances differing only in FADE_STEP.
module tb_light_pwm_driver;

    localparam int ClkDiv = 2;
    localparam int Period = 8;
    localparam int PerClk = ClkDiv * Period;
    localparam int NumVec = 23;

    typedef struct packed {
        logic [2:0] level;
        logic [7:0] duty;
        logic       busy;
    } vec_t;

    typedef struct packed {
        logic [7:0]  duty;
        logic        busy;
        logic [15:0] pat;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] level = 3'd0;
    logic       en = 1'b1;

    logic       pwm0, pwm2, pwm3, ps0, ps2, ps3, busy0, busy2, busy3;
    logic [7:0] duty0, duty2, duty3;

    int         sel = 0;
    logic       pwm, ps, busy;
    logic [7:0] duty;

    int   errors = 0;
    int   checks = 0;
    vec_t vecs [0:NumVec-1];
    exp_t sb [$];

    always #5 clk = ~clk;

    light_pwm_driver #(.CLK_DIV(ClkDiv), .PERIOD(Period), .FADE_STEP(0), .DUTY_W(8)) dut0 (
        .i_clk(clk), .i_reset(rst), .i_lightState(level), .i_enable(en),
        .o_pwm(pwm0), .o_duty(duty0), .o_period_start(ps0), .o_busy(busy0)
    );
    light_pwm_driver #(.CLK_DIV(ClkDiv), .PERIOD(Period), .FADE_STEP(2), .DUTY_W(8)) dut2 (
        .i_clk(clk), .i_reset(rst), .i_lightState(level), .i_enable(en),
        .o_pwm(pwm2), .o_duty(duty2), .o_period_start(ps2), .o_busy(busy2)
    );
    light_pwm_driver #(.CLK_DIV(ClkDiv), .PERIOD(Period), .FADE_STEP(3), .DUTY_W(8)) dut3 (
        .i_clk(clk), .i_reset(rst), .i_lightState(level), .i_enable(en),
        .o_pwm(pwm3), .o_duty(duty3), .o_period_start(ps3), .o_busy(busy3)
    );

    // Route the instance under test to common observation signals.
    always_comb begin
        pwm = pwm0; duty = duty0; ps = ps0; busy = busy0;
        case (sel)
            2: begin pwm = pwm2; duty = duty2; ps = ps2; busy = busy2; end
            3: begin pwm = pwm3; duty = duty3; ps = ps3; busy = busy3; end
            default: ;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected PWM samples over one period starting at the period-start cycle.
    function automatic logic [15:0] pat_of(input int d);
        logic [15:0] p;
        for (int k = 0; k < 16; k++) p[k] = ((k / ClkDiv) < d);
        return p;
    endfunction

    function automatic exp_t mk_exp(input vec_t v);
        exp_t e;
        e.duty = v.duty;
        e.busy = v.busy;
        e.pat  = pat_of(int'(v.duty));
        return e;
    endfunction

    task automatic wait_ps(input string name, input int limit, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ps !== 1'b1 && n < limit);
        if (ps !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s: no period start within %0d cycles", name, limit);
        end
    endtask

    task automatic do_reset(input logic [2:0] lvl);
        @(negedge clk);
        rst   = 1'b1;
        level = lvl;
        en    = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_duty", duty, 0);
        check("reset_pwm", pwm, 0);
        check("reset_ps", ps, 0);
        check("reset_busy", busy, 0);
        rst = 1'b0;
    endtask

    // Called on a period-start cycle; samples o_pwm for a whole period, ends on the next start.
    // mode 1 wiggles the level mid-period, mode 2 pulses enable low for 5 clocks.
    task automatic collect_period(input int mode, output logic [15:0] pat);
        int mid_ps;
        mid_ps = 0;
        for (int k = 0; k < 16; k++) begin
            if (k > 0) begin
                @(negedge clk);
                if (ps === 1'b1) mid_ps++;
            end
            pat[k] = pwm;
            if (mode == 1 && k == 3) level = 3'd3;
            if (mode == 1 && k == 8) level = 3'd2;
            if (mode == 2 && k == 2) en = 1'b0;
            if (mode == 2 && k == 7) en = 1'b1;
        end
        @(negedge clk);
        check("ps_mid_period", mid_ps, 0);
        check("ps_at_wrap", ps, 1);
    endtask

    task automatic run_table(input int first, input int last);
        int          n;
        logic [15:0] pat;
        do_reset(vecs[first].level);
        sb.push_back(mk_exp(vecs[first]));
        wait_ps("first_boundary", 40, n);
        check("first_boundary_cycles", n, PerClk);
        for (int i = first + 1; i <= last + 1; i++) begin
            exp_t e;
            e = sb.pop_front();
            check($sformatf("duty[%0d]", i - 1), duty, e.duty);
            check($sformatf("busy[%0d]", i - 1), busy, e.busy);
            if (i <= last) begin
                level = vecs[i].level;
                sb.push_back(mk_exp(vecs[i]));
            end
            collect_period(0, pat);
            check($sformatf("pwm_pattern[%0d]", i - 1), pat, e.pat);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int          n;
        logic [15:0] pat;

        // FADE_STEP=0: {level, duty applied at next boundary, busy at that boundary}
        vecs[0]  = '{3'd2, 8'd4, 1'b0};
        vecs[1]  = '{3'd2, 8'd4, 1'b0};
        vecs[2]  = '{3'd4, 8'd8, 1'b0};
        vecs[3]  = '{3'd4, 8'd8, 1'b0};
        vecs[4]  = '{3'd0, 8'd0, 1'b0};
        vecs[5]  = '{3'd1, 8'd2, 1'b0};
        vecs[6]  = '{3'd3, 8'd6, 1'b0};
        vecs[7]  = '{3'd6, 8'd0, 1'b0};
        vecs[8]  = '{3'd4, 8'd8, 1'b0};
        vecs[9]  = '{3'd7, 8'd0, 1'b0};
        vecs[10] = '{3'd5, 8'd0, 1'b0};
        vecs[11] = '{3'd2, 8'd4, 1'b0};
        // FADE_STEP=2, ramp 0 -> 8
        vecs[12] = '{3'd4, 8'd2, 1'b1};
        vecs[13] = '{3'd4, 8'd4, 1'b1};
        vecs[14] = '{3'd4, 8'd6, 1'b1};
        vecs[15] = '{3'd4, 8'd8, 1'b0};
        vecs[16] = '{3'd4, 8'd8, 1'b0};
        // FADE_STEP=3, ramp up then down to level 1
        vecs[17] = '{3'd4, 8'd3, 1'b1};
        vecs[18] = '{3'd4, 8'd6, 1'b1};
        vecs[19] = '{3'd4, 8'd8, 1'b0};
        vecs[20] = '{3'd1, 8'd5, 1'b1};
        vecs[21] = '{3'd1, 8'd2, 1'b0};
        vecs[22] = '{3'd1, 8'd2, 1'b0};

        sel = 0;
        run_table(0, 11);

        // Mid-period level changes are ignored; only the boundary sample counts.
        check("wiggle_pre_duty", duty, 4);
        collect_period(1, pat);
        check("wiggle_pattern", pat, pat_of(4));
        check("wiggle_duty", duty, 4);
        check("wiggle_busy", busy, 0);
        collect_period(0, pat);
        check("wiggle_next_pattern", pat, pat_of(4));

        // Enable pulse low for 5 clocks during a duty-6 period.
        level = 3'd3;
        collect_period(0, pat);
        check("en_pre_duty", duty, 6);
        collect_period(2, pat);
        check("en_pulse_pattern", pat, pat_of(6) & ~16'h01F0);
        check("en_post_duty", duty, 6);
        collect_period(0, pat);
        check("en_restored_pattern", pat, pat_of(6));

        sel = 2;
        run_table(12, 16);
        sel = 3;
        run_table(17, 22);

        // Asynchronous reset mid-fade with duty 6 and busy set.
        sel = 2;
        do_reset(3'd4);
        wait_ps("fade_p1", 40, n);
        wait_ps("fade_p2", 40, n);
        wait_ps("fade_p3", 40, n);
        check("pre_rst_duty", duty, 6);
        check("pre_rst_busy", busy, 1);
        check("pre_rst_ps", ps, 1);
        check("pre_rst_pwm", pwm, 1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_duty", duty, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_ps", ps, 0);
        check("async_rst_pwm", pwm, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_ps("post_rst_boundary", 40, n);
        check("post_rst_cycles", n, PerClk);
        check("post_rst_duty", duty, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
